// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared definitions for the OPC5 UART receiver
package uart_rx_pkg;

   // Receiver FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_t;

   // STATUS register bit positions
   localparam int STAT_VALID   = 0;
   localparam int STAT_OVERRUN = 1;
   localparam int STAT_FERR    = 2;

   // Bus addresses of the UART pair (each occupies two words)
   localparam logic [15:0] UART_TX_BASE = 16'hfe08;
   localparam logic [15:0] UART_RX_BASE = 16'hfe0a;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - memory-mapped 8N1 UART receiver with polled status/data registers
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLKSPEED = 32000000,
   parameter int BAUD     = 115200
) (
   input  logic        clk,
   input  logic        reset_b,
   inout  wire  [15:0] data,
   input  logic        a0,
   input  logic        rnw,
   input  logic        cs_b,
   input  logic        rxd,
   output logic        rx_ready
);

   localparam int DIVISOR = (CLKSPEED + BAUD / 2) / BAUD;
   localparam int HALF    = DIVISOR / 2;
   localparam int CNT_W   = $clog2(DIVISOR);

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIVISOR - 1);

   logic             rxd_m;
   logic             rxd_s;
   rx_state_t        state;
   rx_state_t        state_d;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift;
   logic [7:0]       hold;
   logic             valid;
   logic             overrun;
   logic             ferr;
   logic             cnt_zero;
   logic             bit_last;
   logic             load_half;
   logic             load_full;
   logic             clr_bit;
   logic             do_shift;
   logic             commit;
   logic             rd_data;
   logic [15:0]      status;
   logic [15:0]      rd_mux;

   assign cnt_zero = (cnt == '0);
   assign bit_last = (bit_cnt == 3'd7);
   assign rd_data  = !cs_b && rnw && a0;
   assign rx_ready = valid;

   // Two-flop synchroniser; the line idles high so reset to 1
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         rxd_m <= rxd;
         rxd_s <= rxd_m;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) state <= ST_IDLE;
      else          state <= state_d;
   end

   // Next-state and datapath strobes; STOP returns to IDLE mid-bit so back-to-back frames are caught
   always_comb begin
      state_d   = state;
      load_half = 1'b0;
      load_full = 1'b0;
      clr_bit   = 1'b0;
      do_shift  = 1'b0;
      commit    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rxd_s) begin
               state_d   = ST_START;
               load_half = 1'b1;
            end
         end
         ST_START: begin
            if (cnt_zero) begin
               if (!rxd_s) begin
                  state_d   = ST_DATA;
                  load_full = 1'b1;
                  clr_bit   = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (cnt_zero) begin
               do_shift  = 1'b1;
               load_full = 1'b1;
               if (bit_last) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt_zero) begin
               commit  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Baud counter: reloads on strobes, otherwise counts down and parks at zero
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b)         cnt <= '0;
      else if (load_half)   cnt <= CNT_HALF;
      else if (load_full)   cnt <= CNT_FULL;
      else if (!cnt_zero)   cnt <= cnt - 1'b1;
   end

   // Shift register and bit counter, LSB arrives first so shift right
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         bit_cnt <= 3'd0;
         shift   <= 8'h00;
      end else if (clr_bit) begin
         bit_cnt <= 3'd0;
      end else if (do_shift) begin
         bit_cnt <= bit_cnt + 3'd1;
         shift   <= {rxd_s, shift[7:1]};
      end
   end

   // Holding register and flags; a frame commit takes priority over clear-on-read
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         hold    <= 8'h00;
         valid   <= 1'b0;
         overrun <= 1'b0;
         ferr    <= 1'b0;
      end else if (commit) begin
         hold    <= shift;
         valid   <= 1'b1;
         ferr    <= ~rxd_s;
         overrun <= overrun | valid;
      end else if (rd_data) begin
         valid   <= 1'b0;
         overrun <= 1'b0;
         ferr    <= 1'b0;
      end
   end

   // Register read mux
   always_comb begin
      status               = 16'h0000;
      status[STAT_VALID]   = valid;
      status[STAT_OVERRUN] = overrun;
      status[STAT_FERR]    = ferr;
      rd_mux = a0 ? {8'h00, hold} : status;
   end

   assign data = (!cs_b && rnw) ? rd_mux : 16'hzzzz;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

   localparam int BIT_CLKS = 278;
   localparam int LATENCY  = 2644;

   logic       clk     = 1'b0;
   logic       reset_b = 1'b0;
   logic       a0      = 1'b0;
   logic       rnw     = 1'b1;
   logic       cs_b    = 1'b1;
   logic       rxd     = 1'b1;
   logic       rx_ready;
   wire [15:0] data;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [7:0] b;
      logic       stop;
   } frame_t;

   typedef struct {
      logic [7:0]  b;
      logic        stop;
      logic [15:0] exp_status;
      logic [15:0] exp_data;
   } vec_t;

   frame_t sb_q[$];
   vec_t   vecs[6];

   uart_rx dut (
      .clk      (clk),
      .reset_b  (reset_b),
      .data     (data),
      .a0       (a0),
      .rnw      (rnw),
      .cs_b     (cs_b),
      .rxd      (rxd),
      .rx_ready (rx_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic read_reg(input logic addr, output logic [15:0] val);
      cs_b = 1'b0;
      rnw  = 1'b1;
      a0   = addr;
      #1 val = data;
      @(posedge clk);
      #1;
      cs_b = 1'b1;
   endtask

   task automatic write_reg(input logic addr);
      cs_b = 1'b0;
      rnw  = 1'b0;
      a0   = addr;
      @(posedge clk);
      #1;
      cs_b = 1'b1;
      rnw  = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      frame_t f;
      f.b    = b;
      f.stop = stop;
      sb_q.push_back(f);
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd = bits[i];
         repeat (BIT_CLKS) @(posedge clk);
         #1;
      end
      rxd = 1'b1;
   endtask

   function automatic logic [15:0] sb_status();
      logic [15:0] s;
      s = 16'h0000;
      if (sb_q.size() > 0) begin
         s[0] = 1'b1;
         s[1] = (sb_q.size() > 1);
         s[2] = ~sb_q[sb_q.size()-1].stop;
      end
      return s;
   endfunction

   function automatic logic [15:0] sb_data();
      if (sb_q.size() == 0) return 16'h0000;
      return {8'h00, sb_q[sb_q.size()-1].b};
   endfunction

   task automatic drain_check(input string name);
      logic [15:0] v;
      read_reg(1'b0, v);
      check({name, "_status"}, v, sb_status());
      read_reg(1'b1, v);
      check({name, "_data"}, v, sb_data());
      sb_q.delete();
      read_reg(1'b0, v);
      check({name, "_status_after"}, v, 16'h0000);
   endtask

   initial begin
      logic [15:0] v;
      int          lat;

      vecs[0] = '{8'hA5, 1'b1, 16'h0001, 16'h00A5};
      vecs[1] = '{8'h3C, 1'b0, 16'h0005, 16'h003C};
      vecs[2] = '{8'h81, 1'b1, 16'h0001, 16'h0081};
      vecs[3] = '{8'h00, 1'b1, 16'h0001, 16'h0000};
      vecs[4] = '{8'hFF, 1'b1, 16'h0001, 16'h00FF};
      vecs[5] = '{8'h55, 1'b0, 16'h0005, 16'h0055};

      // reset state
      idle(3);
      read_reg(1'b0, v);
      check("reset_status", v, 16'h0000);
      check("reset_rx_ready", {15'h0, rx_ready}, 16'h0000);
      reset_b = 1'b1;
      idle(10);

      // first frame with latency measurement
      lat = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            while (rx_ready !== 1'b1 && lat < 4000) begin
               @(posedge clk);
               #1;
               lat++;
            end
         end
      join
      check("latency", 16'(lat), 16'(LATENCY));
      drain_check("single_a5");
      idle(20);

      // table-driven single frames
      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].b, vecs[i].stop);
         check("vec_rx_ready", {15'h0, rx_ready}, 16'h0001);
         read_reg(1'b0, v);
         check("vec_status", v, vecs[i].exp_status);
         check("vec_status_sb", v, sb_status());
         read_reg(1'b1, v);
         check("vec_data", v, vecs[i].exp_data);
         sb_q.delete();
         read_reg(1'b0, v);
         check("vec_status_cleared", v, 16'h0000);
         idle(20);
      end

      // back-to-back frames without reading: overrun
      send_frame(8'h12, 1'b1);
      send_frame(8'h34, 1'b1);
      read_reg(1'b0, v);
      check("b2b_status", v, 16'h0003);
      read_reg(1'b1, v);
      check("b2b_data", v, 16'h0034);
      sb_q.delete();
      read_reg(1'b0, v);
      check("b2b_status_after", v, 16'h0000);
      idle(20);

      // short glitch shorter than half a bit is rejected
      rxd = 1'b0;
      idle(100);
      rxd = 1'b1;
      idle(500);
      read_reg(1'b0, v);
      check("glitch_status", v, 16'h0000);
      send_frame(8'h81, 1'b1);
      drain_check("after_glitch");
      idle(20);

      // writes and STATUS reads have no side effects
      send_frame(8'hC3, 1'b1);
      write_reg(1'b1);
      write_reg(1'b0);
      read_reg(1'b0, v);
      check("write_status1", v, 16'h0001);
      read_reg(1'b0, v);
      check("write_status2", v, 16'h0001);
      drain_check("write_ignored");
      idle(20);

      // DATA read held on the exact commit clock: commit wins
      send_frame(8'h11, 1'b1);
      fork
         send_frame(8'h7E, 1'b1);
         begin
            repeat (LATENCY - 1) @(posedge clk);
            #1;
            cs_b = 1'b0;
            rnw  = 1'b1;
            a0   = 1'b1;
            @(posedge clk);
            #1;
            cs_b = 1'b1;
            check("commit_read_rx_ready", {15'h0, rx_ready}, 16'h0001);
         end
      join
      drain_check("commit_vs_read");
      idle(20);

      // reset mid-frame discards the frame
      rxd = 1'b0;
      idle(BIT_CLKS + 500);
      reset_b = 1'b0;
      idle(3);
      rxd = 1'b1;
      idle(3);
      reset_b = 1'b1;
      idle(3000);
      check("midreset_rx_ready", {15'h0, rx_ready}, 16'h0000);
      read_reg(1'b0, v);
      check("midreset_status", v, 16'h0000);
      send_frame(8'h5A, 1'b1);
      drain_check("after_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
